// File: rtl/pix_stream_gen.sv
// Sensor-style pixel stream generator: frame/line valid plus 12-bit pixel data with programmable blanking.
// Optional build macro PIXSTREAM_FRAME_TAG_EN puts frame_count[3:0] on pix_d[11:8].
module pix_stream_gen #(
  parameter int ImageWidth  = 16,
  parameter int ImageHeight = 16,
  parameter int HBlank      = 4,
  parameter int VBlank      = 8,
  parameter int FvLead      = 2,
  parameter int FvTrail     = 2
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic        en,
  output logic [11:0] pix_d,
  output logic        pix_fv,
  output logic        pix_lv,
  output logic        frame_done,
  output logic [7:0]  frame_count
);

  localparam int MaxA = (ImageWidth > HBlank) ? ImageWidth : HBlank;
  localparam int MaxB = (VBlank > FvLead) ? VBlank : FvLead;
  localparam int MaxC = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int MaxT = (MaxC > FvTrail) ? MaxC : FvTrail;
  localparam int CW   = (MaxT > 1) ? $clog2(MaxT) : 1;
  localparam int LW   = (ImageHeight > 1) ? $clog2(ImageHeight) : 1;

  localparam logic [CW-1:0] C_W_LAST  = CW'(ImageWidth - 1);
  localparam logic [CW-1:0] C_HB_LAST = CW'(HBlank - 1);
  localparam logic [CW-1:0] C_VB_LAST = CW'(VBlank - 1);
  localparam logic [CW-1:0] C_LD_LAST = CW'(FvLead - 1);
  localparam logic [CW-1:0] C_TR_LAST = CW'(FvTrail - 1);
  localparam logic [LW-1:0] C_H_LAST  = LW'(ImageHeight - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_VBLANK, S_LEAD, S_LINE, S_HBLANK, S_TRAIL
  } state_t;

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [LW-1:0] r_line, w_line_next;
  logic [11:0]   r_pix, w_pix_next;
  logic [11:0]   r_pix_d, w_d_next;
  logic          r_fv, w_fv_next;
  logic          r_lv, w_lv_next;
  logic          r_done, w_done_next;
  logic [7:0]    r_frame_count, w_count_next;

  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_line        <= '0;
      r_pix         <= '0;
      r_pix_d       <= '0;
      r_fv          <= 1'b0;
      r_lv          <= 1'b0;
      r_done        <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_line        <= w_line_next;
      r_pix         <= w_pix_next;
      r_pix_d       <= w_d_next;
      r_fv          <= w_fv_next;
      r_lv          <= w_lv_next;
      r_done        <= w_done_next;
      r_frame_count <= w_count_next;
    end
  end

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_line_next  = r_line;
    w_pix_next   = r_pix;
    w_done_next  = 1'b0;
    w_count_next = r_frame_count;
    w_d_next     = '0;
    case (r_state)
      S_IDLE: begin
        if (en) begin
          w_state_next = S_VBLANK;
          w_cnt_next   = '0;
          w_pix_next   = '0;
        end
      end
      S_VBLANK: begin
        if (r_cnt == C_VB_LAST) begin
          w_state_next = S_LEAD;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_LEAD: begin
        if (r_cnt == C_LD_LAST) begin
          w_state_next = S_LINE;
          w_cnt_next   = '0;
          w_line_next  = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_LINE: begin
        if (r_cnt == C_W_LAST) begin
          w_cnt_next = '0;
          if (r_line == C_H_LAST) begin
            w_state_next = S_TRAIL;
          end else begin
            w_state_next = S_HBLANK;
            w_line_next  = r_line + 1'b1;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_HBLANK: begin
        if (r_cnt == C_HB_LAST) begin
          w_state_next = S_LINE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_TRAIL: begin
        if (r_cnt == C_TR_LAST) begin
          w_state_next = en ? S_VBLANK : S_IDLE;
          w_cnt_next   = '0;
          w_pix_next   = '0;
          w_done_next  = 1'b1;
          w_count_next = r_frame_count + 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase

    w_fv_next = (w_state_next == S_LEAD) || (w_state_next == S_LINE) ||
                (w_state_next == S_HBLANK) || (w_state_next == S_TRAIL);
    w_lv_next = (w_state_next == S_LINE);
    // r_pix holds the index of the next pixel to be emitted.
    if (w_lv_next) begin
`ifdef PIXSTREAM_FRAME_TAG_EN
      w_d_next = {r_frame_count[3:0], r_pix[7:0]};
`else
      w_d_next = r_pix;
`endif
      w_pix_next = r_pix + 1'b1;
    end
  end

`ifdef PIXSTREAM_FRAME_TAG_EN
  logic w_unused_pix_hi;
  assign w_unused_pix_hi = ^r_pix[11:8];
`endif

  assign pix_d       = r_pix_d;
  assign pix_fv      = r_fv;
  assign pix_lv      = r_lv;
  assign frame_done  = r_done;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_pix_stream_gen.sv
// Randomized self-checking bench for pix_stream_gen against a formula-based frame model.
// Instance a uses default geometry; instance b uses 64x80 to exercise the pixel counter wrap.
module tb_pix_stream_gen;

  localparam int HB = 4;
  localparam int VB = 8;
  localparam int LD = 2;
  localparam int TR = 2;

  logic clk;
  logic rst_a, en_a, rst_b, en_b;
  logic [11:0] d_a, d_b;
  logic fv_a, lv_a, done_a, fv_b, lv_b, done_b;
  logic [7:0] cnt_a, cnt_b;
  logic sel;

  int checks = 0;
  int failures = 0;
  int frames = 0;

  pix_stream_gen u_dut_a (
    .clk(clk), .rst_(rst_a), .en(en_a), .pix_d(d_a), .pix_fv(fv_a),
    .pix_lv(lv_a), .frame_done(done_a), .frame_count(cnt_a)
  );

  pix_stream_gen #(.ImageWidth(64), .ImageHeight(80)) u_dut_b (
    .clk(clk), .rst_(rst_b), .en(en_b), .pix_d(d_b), .pix_fv(fv_b),
    .pix_lv(lv_b), .frame_done(done_b), .frame_count(cnt_b)
  );

  wire [11:0] d_s    = sel ? d_b : d_a;
  wire        fv_s   = sel ? fv_b : fv_a;
  wire        lv_s   = sel ? lv_b : lv_a;
  wire        done_s = sel ? done_b : done_a;
  wire [7:0]  cnt_s  = sel ? cnt_b : cnt_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Expected pix_d for pixel p of a frame emitted while frame_count == fc.
  function automatic int exp_pix(input int p, input int fc);
`ifdef PIXSTREAM_FRAME_TAG_EN
    return ((fc & 15) << 8) | (p & 255);
`else
    return p % 4096;
`endif
  endfunction

  // Counts fv-low samples until fv rises; lows = -1 if it never does.
  task automatic wait_rise(output int lows, output int dones, output int lvs);
    bit seen;
    seen = 0; lows = 0; dones = 0; lvs = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(posedge clk); #1;
      if (fv_s) seen = 1;
      else begin
        lows++;
        if (done_s) dones++;
        if (lv_s) lvs++;
      end
    end
    if (!seen) lows = -1;
  endtask

  task automatic watch_idle(input int n, output int highs);
    highs = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (fv_s || lv_s || done_s) highs++;
    end
  endtask

  // Called on the first fv-high sample; checks the whole frame plus the frame_done sample.
  task automatic check_frame(input int w, input int h, input int fc, input int drop_t);
    int len, errs, npix, lastd, u, ln, col, exp_d;
    bit exp_lv;
    len = LD + h * w + (h - 1) * HB + TR;
    errs = 0; npix = 0; lastd = -1;
    for (int t = 0; t < len; t++) begin
      if (t > 0) begin
        @(posedge clk); #1;
      end
      if (t == drop_t) begin
        if (sel) en_b = 1'b0;
        else en_a = 1'b0;
      end
      exp_lv = 1'b0; exp_d = 0;
      if (t >= LD) begin
        u = t - LD;
        ln = u / (w + HB);
        col = u % (w + HB);
        if (ln < h && col < w) begin
          exp_lv = 1'b1;
          exp_d = exp_pix(ln * w + col, (fc - 1) & 255);
        end
      end
      if (!fv_s || lv_s != exp_lv || int'(d_s) != exp_d || done_s) errs++;
      if (lv_s) begin
        npix++;
        lastd = int'(d_s);
      end
    end
    check("frame_wave", errs, 0);
    check("frame_npix", npix, h * w);
    check("frame_last_d", lastd, exp_pix(h * w - 1, (fc - 1) & 255));
    @(posedge clk); #1;
    check("done_fv", int'(fv_s), 0);
    check("done_lv", int'(lv_s), 0);
    check("done_pulse", int'(done_s), 1);
    check("done_count", int'(cnt_s), fc & 255);
    frames++;
    $display("frame %0d dut=%0d size=%0dx%0d pixels=%0d last_d=%0d count=%0d wave_errs=%0d",
             frames, sel, w, h, npix, lastd, cnt_s, errs);
  endtask

  int lows, dones, lvs, highs, col_drop, hold;

  initial begin
    sel = 1'b0;
    rst_a = 1'b0; en_a = 1'b0;
    rst_b = 1'b0; en_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_fv", int'(fv_a), 0);
    check("rst_lv", int'(lv_a), 0);
    check("rst_d", int'(d_a), 0);
    check("rst_done", int'(done_a), 0);
    check("rst_count", int'(cnt_a), 0);

    rst_a = 1'b1;
    watch_idle(20, highs);
    check("idle_quiet", highs, 0);

    // First frame from Idle: en sampled on the next edge, fv rises after VB low samples.
    en_a = 1'b1;
    wait_rise(lows, dones, lvs);
    check("rise_from_idle", lows, VB);
    check("vblank_lv", lvs, 0);
    check_frame(16, 16, 1, -1);

    // Back-to-back frames: the frame_done sample is the first of the VB low cycles.
    for (int f = 2; f <= 3; f++) begin
      wait_rise(lows, dones, lvs);
      check("rise_b2b", lows, VB - 1);
      check("done_single", dones, 0);
      check_frame(16, 16, f, -1);
    end

    // en dropped mid-line on line 5: frame completes, then stays idle.
    col_drop = $urandom_range(1, 14);
    wait_rise(lows, dones, lvs);
    check("rise_b2b", lows, VB - 1);
    check_frame(16, 16, 4, LD + 5 * (16 + HB) + col_drop);
    watch_idle(60, highs);
    check("idle_after_drop", highs, 0);

    // Reset for one cycle at a random point inside a frame.
    en_a = 1'b1;
    wait_rise(lows, dones, lvs);
    check("rise_from_idle2", lows, VB);
    hold = $urandom_range(1, 300);
    repeat (hold) @(posedge clk);
    #1;
    rst_a = 1'b0;
    @(posedge clk); #1;
    check("midrst_fv", int'(fv_a), 0);
    check("midrst_lv", int'(lv_a), 0);
    check("midrst_d", int'(d_a), 0);
    check("midrst_count", int'(cnt_a), 0);
    check("midrst_done", int'(done_a), 0);
    $display("mid-frame reset after %0d fv-high cycles", hold + 1);
    rst_a = 1'b1;
    wait_rise(lows, dones, lvs);
    check("rise_after_rst", lows, VB);
    check("rst_no_done", dones, 0);
    check_frame(16, 16, 1, 1);

    // 64x80 geometry: 5120 pixels, counter wraps past 4095.
    sel = 1'b1;
    rst_b = 1'b1;
    @(posedge clk); #1;
    en_b = 1'b1;
    wait_rise(lows, dones, lvs);
    check("rise_big", lows, VB);
    check_frame(64, 80, 1, 1);
    watch_idle(20, highs);
    check("idle_big", highs, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
